// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: widths, response/burst codes, slave FSM states and request payloads.
package axi4_pkg;

   localparam int unsigned ID_W    = 4;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam int unsigned LEN_W   = 8;
   localparam int unsigned SIZE_W  = 3;
   localparam int unsigned BURST_W = 2;
   localparam int unsigned RESP_W  = 2;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

   localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
   localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
   localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
   localparam logic [BURST_W-1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_COLLECT,
      ST_W_WAIT,
      ST_W_RESP,
      ST_R_WAIT,
      ST_R_RESP
   } slave_state_e;

   // Address-channel payload (AW or AR)
   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [ID_W-1:0]    id;
      logic [LEN_W-1:0]   len;
      logic [SIZE_W-1:0]  size;
      logic [BURST_W-1:0] burst;
   } addr_req_t;

   // Write-data-channel payload
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } wbeat_t;

   // Response code for a single-beat request; decode errors win over slave errors
   function automatic logic [RESP_W-1:0] check_resp(input addr_req_t         req,
                                                    input logic              is_write,
                                                    input logic              wlast,
                                                    input logic [ADDR_W-1:0] base,
                                                    input int unsigned       idx_w);
      logic [ADDR_W-1:0] off;
      off = req.addr - base;
      if ((req.addr < base) || ((off >> (idx_w + 2)) != '0)) return RESP_DECERR;
      if ((req.len != '0) || (req.size > 3'd2) || (req.burst == BURST_RSVD) ||
          (is_write && !wlast)) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/sram_bytemask_mem.sv
// Word-addressed SRAM with synchronous byte-masked write and synchronous read.
module sram_bytemask_mem
   import axi4_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic [STRB_W-1:0]              wr_strb,
   input  logic                           rd_en,
   input  logic                           rd_clr,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
   output logic [DATA_W-1:0]              rd_data
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   // Byte-masked write; array contents survive reset
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
         end
      end
   end

   // Registered read port; rd_clr returns zero for errored reads
   always_ff @(posedge clock) begin
      if (!reset)     rd_data <= '0;
      else if (rd_en) rd_data <= rd_clr ? '0 : mem[rd_idx];
   end

endmodule

// File: rtl/axi4_sram_slave.sv
// Single-beat AXI4 slave over a byte-maskable SRAM with programmable response latency.
module axi4_sram_slave
   import axi4_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h8000_0000,
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter int unsigned       LATENCY     = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               io_slave_awvalid,
   output logic               io_slave_awready,
   input  logic [ADDR_W-1:0]  io_slave_awaddr,
   input  logic [ID_W-1:0]    io_slave_awid,
   input  logic [LEN_W-1:0]   io_slave_awlen,
   input  logic [SIZE_W-1:0]  io_slave_awsize,
   input  logic [BURST_W-1:0] io_slave_awburst,
   input  logic               io_slave_wvalid,
   output logic               io_slave_wready,
   input  logic [DATA_W-1:0]  io_slave_wdata,
   input  logic [STRB_W-1:0]  io_slave_wstrb,
   input  logic               io_slave_wlast,
   output logic               io_slave_bvalid,
   input  logic               io_slave_bready,
   output logic [RESP_W-1:0]  io_slave_bresp,
   output logic [ID_W-1:0]    io_slave_bid,
   input  logic               io_slave_arvalid,
   output logic               io_slave_arready,
   input  logic [ADDR_W-1:0]  io_slave_araddr,
   input  logic [ID_W-1:0]    io_slave_arid,
   input  logic [LEN_W-1:0]   io_slave_arlen,
   input  logic [SIZE_W-1:0]  io_slave_arsize,
   input  logic [BURST_W-1:0] io_slave_arburst,
   output logic               io_slave_rvalid,
   input  logic               io_slave_rready,
   output logic [DATA_W-1:0]  io_slave_rdata,
   output logic [RESP_W-1:0]  io_slave_rresp,
   output logic [ID_W-1:0]    io_slave_rid,
   output logic               io_slave_rlast
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

   slave_state_e      state_q, state_d;
   logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic              pri_rd_q, pri_rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   addr_req_t         aw_q, ar_q, aw_in, ar_in, aw_eff, ar_eff;
   wbeat_t            w_q, w_in, w_eff;
   logic              aw_rdy, w_rdy, ar_rdy, ar_win;
   logic              aw_hs, w_hs, ar_hs, have_aw, have_w;
   logic              enter_wresp, enter_rresp;
   logic [RESP_W-1:0] wr_resp, rd_resp;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic              bvalid_q, rvalid_q, rlast_q;
   logic [RESP_W-1:0] bresp_q, rresp_q;
   logic [ID_W-1:0]   bid_q, rid_q;

   assign aw_in = '{addr: io_slave_awaddr, id: io_slave_awid, len: io_slave_awlen,
                    size: io_slave_awsize, burst: io_slave_awburst};
   assign ar_in = '{addr: io_slave_araddr, id: io_slave_arid, len: io_slave_arlen,
                    size: io_slave_arsize, burst: io_slave_arburst};
   assign w_in  = '{data: io_slave_wdata, strb: io_slave_wstrb, last: io_slave_wlast};

   assign ar_win = io_slave_arvalid && (pri_rd_q || !(io_slave_awvalid || io_slave_wvalid));

   // Ready generation: capture is only offered while the FSM can accept it
   always_comb begin
      ar_rdy = 1'b0;
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      if (reset) begin
         case (state_q)
            ST_IDLE: begin
               if (ar_win) ar_rdy = 1'b1;
               else begin
                  aw_rdy = !aw_got_q;
                  w_rdy  = !w_got_q;
               end
            end
            ST_W_COLLECT: begin
               aw_rdy = !aw_got_q;
               w_rdy  = !w_got_q;
            end
            default: ;
         endcase
      end
   end

   assign aw_hs   = io_slave_awvalid && aw_rdy;
   assign w_hs    = io_slave_wvalid  && w_rdy;
   assign ar_hs   = io_slave_arvalid && ar_rdy;
   assign have_aw = aw_got_q || aw_hs;
   assign have_w  = w_got_q  || w_hs;
   assign cnt_inc = cnt_q + CNT_W'(1);

   // Current request view: this-cycle handshake payload bypasses the capture registers
   assign aw_eff  = aw_hs ? aw_in : aw_q;
   assign w_eff   = w_hs  ? w_in  : w_q;
   assign ar_eff  = ar_hs ? ar_in : ar_q;
   assign wr_resp = check_resp(aw_eff, 1'b1, w_eff.last, ADDR_BASE, IDX_W);
   assign rd_resp = check_resp(ar_eff, 1'b0, 1'b0, ADDR_BASE, IDX_W);
   assign wr_idx  = IDX_W'((aw_eff.addr - ADDR_BASE) >> 2);
   assign rd_idx  = IDX_W'((ar_eff.addr - ADDR_BASE) >> 2);

   // Next-state logic: arbitration, channel collection, latency wait, response handshake
   always_comb begin
      state_d  = state_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      pri_rd_d = pri_rd_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE, ST_W_COLLECT: begin
            if (ar_hs) begin
               pri_rd_d = !pri_rd_q;
               state_d  = (LATENCY == 0) ? ST_R_RESP : ST_R_WAIT;
            end else if (have_aw && have_w) begin
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               pri_rd_d = !pri_rd_q;
               state_d  = (LATENCY == 0) ? ST_W_RESP : ST_W_WAIT;
            end else begin
               aw_got_d = have_aw;
               w_got_d  = have_w;
               if (have_aw || have_w) state_d = ST_W_COLLECT;
            end
         end
         ST_W_WAIT, ST_R_WAIT: begin
            if (cnt_inc == LAT_C) begin
               cnt_d   = '0;
               state_d = (state_q == ST_W_WAIT) ? ST_W_RESP : ST_R_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_W_RESP: if (io_slave_bready) state_d = ST_IDLE;
         ST_R_RESP: if (io_slave_rready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign enter_wresp = (state_d == ST_W_RESP) && (state_q != ST_W_RESP);
   assign enter_rresp = (state_d == ST_R_RESP) && (state_q != ST_R_RESP);

   // State, bookkeeping and registered response outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
         pri_rd_q <= 1'b1;
         cnt_q    <= '0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         bresp_q  <= '0;
         rresp_q  <= '0;
         bid_q    <= '0;
         rid_q    <= '0;
      end else begin
         state_q  <= state_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
         pri_rd_q <= pri_rd_d;
         cnt_q    <= cnt_d;
         bvalid_q <= (state_d == ST_W_RESP);
         rvalid_q <= (state_d == ST_R_RESP);
         rlast_q  <= (state_d == ST_R_RESP);
         if (enter_wresp) begin
            bresp_q <= wr_resp;
            bid_q   <= aw_eff.id;
         end
         if (enter_rresp) begin
            rresp_q <= rd_resp;
            rid_q   <= ar_eff.id;
         end
      end
   end

   // Request payload capture on each channel handshake
   always_ff @(posedge clock) begin
      if (aw_hs) aw_q <= aw_in;
      if (w_hs)  w_q  <= w_in;
      if (ar_hs) ar_q <= ar_in;
   end

   sram_bytemask_mem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (reset && enter_wresp && (wr_resp == RESP_OKAY)),
      .wr_idx  (wr_idx),
      .wr_data (w_eff.data),
      .wr_strb (w_eff.strb),
      .rd_en   (enter_rresp),
      .rd_clr  (rd_resp != RESP_OKAY),
      .rd_idx  (rd_idx),
      .rd_data (io_slave_rdata)
   );

   assign io_slave_awready = aw_rdy;
   assign io_slave_wready  = w_rdy;
   assign io_slave_arready = ar_rdy;
   assign io_slave_bvalid  = bvalid_q;
   assign io_slave_bresp   = bresp_q;
   assign io_slave_bid     = bid_q;
   assign io_slave_rvalid  = rvalid_q;
   assign io_slave_rresp   = rresp_q;
   assign io_slave_rid     = rid_q;
   assign io_slave_rlast   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: directed vectors, queue-based response checking.
module tb_axi4_sram_slave;

   logic        clock = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, wlast;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  awid, wstrb, arid, bid, rid;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

   typedef struct {
      logic [1:0]  resp;
      logic [3:0]  id;
      logic [31:0] data;
   } exp_t;

   exp_t exp_b[$];
   exp_t exp_r[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   axi4_sram_slave dut (
      .clock(clock), .reset(reset),
      .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_awaddr(awaddr),
      .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
      .io_slave_awburst(awburst),
      .io_slave_wvalid(wvalid), .io_slave_wready(wready), .io_slave_wdata(wdata),
      .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
      .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp),
      .io_slave_bid(bid),
      .io_slave_arvalid(arvalid), .io_slave_arready(arready), .io_slave_araddr(araddr),
      .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
      .io_slave_arburst(arburst),
      .io_slave_rvalid(rvalid), .io_slave_rready(rready), .io_slave_rdata(rdata),
      .io_slave_rresp(rresp), .io_slave_rid(rid), .io_slave_rlast(rlast)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pop the scoreboard on every response handshake
   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset) begin
         if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
               tests++; fails++;
               $display("FAIL b_unexpected: got bid 0x%0h bresp 0x%0h, expected no response", bid, bresp);
            end else begin
               e = exp_b.pop_front();
               chk("bresp", 32'(bresp), 32'(e.resp));
               chk("bid",   32'(bid),   32'(e.id));
            end
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
               tests++; fails++;
               $display("FAIL r_unexpected: got rid 0x%0h rdata 0x%08h, expected no response", rid, rdata);
            end else begin
               e = exp_r.pop_front();
               chk("rresp", 32'(rresp), 32'(e.resp));
               chk("rid",   32'(rid),   32'(e.id));
               chk("rdata", rdata,      e.data);
               chk("rlast", 32'(rlast), 32'd1);
            end
         end
      end
   end

   task automatic issue_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                              input logic [3:0] strb, input logic last, input logic [1:0] exp_resp,
                              input bit push);
      bit aw_done, w_done;
      @(posedge clock); #1;
      if (push) exp_b.push_back('{exp_resp, id, 32'h0});
      awaddr = addr; awid = id; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
      wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
      for (int c = 0; c < 40 && (awvalid || wvalid); c++) begin
         @(negedge clock);
         aw_done = awvalid && awready;
         w_done  = wvalid && wready;
         @(posedge clock); #1;
         if (aw_done) awvalid = 1'b0;
         if (w_done)  wvalid  = 1'b0;
      end
      if (awvalid || wvalid) begin
         chk("write_accept_timeout", {30'b0, awvalid, wvalid}, 32'd0);
         awvalid = 1'b0; wvalid = 1'b0;
      end
   endtask

   task automatic issue_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] exp_resp, input logic [31:0] exp_data,
                             output int waited);
      bit done;
      @(posedge clock); #1;
      exp_r.push_back('{exp_resp, id, exp_data});
      araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
      waited = 0;
      for (int c = 0; c < 40 && arvalid; c++) begin
         @(negedge clock);
         done = arvalid && arready;
         if (!done) waited++;
         @(posedge clock); #1;
         if (done) arvalid = 1'b0;
      end
      if (arvalid) begin
         chk("read_accept_timeout", 32'(arvalid), 32'd0);
         arvalid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 100 && (exp_b.size() != 0 || exp_r.size() != 0); c++) @(negedge clock);
      chk("drain_b", 32'(exp_b.size()), 32'd0);
      chk("drain_r", 32'(exp_r.size()), 32'd0);
      exp_b.delete();
      exp_r.delete();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin : stim
      int  waited, lat, r_cyc, aw_cyc, bcnt;
      bit  ar_done, aw_done, w_done;

      reset = 1'b0;
      awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
      arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
      bready = 1'b1; rready = 1'b1;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready",  32'(wready),  32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_bvalid",  32'(bvalid),  32'd0);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      chk("rst_rlast",   32'(rlast),   32'd0);
      chk("rst_bresp",   32'(bresp),   32'd0);
      chk("rst_rid",     32'(rid),     32'd0);
      @(posedge clock); #1;
      reset = 1'b1;

      // Basic write with latency measurement, then read back
      issue_write(32'h8000_0010, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b1, 2'b00, 1'b1);
      lat = 0;
      for (int c = 0; c < 20 && lat == 0; c++) begin
         @(negedge clock);
         if (bvalid) lat = c + 1;
      end
      chk("b_latency", 32'(lat), 32'd3);
      wait_drain();
      issue_read(32'h8000_0010, 4'd5, 8'd0, 2'b00, 32'hDEAD_BEEF, waited);
      wait_drain();

      // W before AW with partial strobe
      @(posedge clock); #1;
      exp_b.push_back('{2'b00, 4'd6, 32'h0});
      wdata = 32'h1122_3344; wstrb = 4'h3; wlast = 1'b1; wvalid = 1'b1;
      @(negedge clock);
      chk("ooo_wready", 32'(wready), 32'd1);
      @(posedge clock); #1;
      wvalid = 1'b0;
      @(negedge clock);
      chk("collect_wready",  32'(wready),  32'd0);
      chk("collect_awready", 32'(awready), 32'd1);
      @(posedge clock); #1;
      awaddr = 32'h8000_0010; awid = 4'd6; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
      @(negedge clock);
      chk("ooo_awready", 32'(awready), 32'd1);
      @(posedge clock); #1;
      awvalid = 1'b0;
      wait_drain();
      issue_read(32'h8000_0010, 4'd2, 8'd0, 2'b00, 32'hDEAD_3344, waited);
      wait_drain();

      // Arbitration after reset: read first, write right after the read handshake
      @(posedge clock); #1; reset = 1'b0;
      @(posedge clock); #1; reset = 1'b1;
      exp_r.push_back('{2'b00, 4'd1, 32'hDEAD_3344});
      exp_b.push_back('{2'b00, 4'd7, 32'h0});
      araddr = 32'h8000_0010; arid = 4'd1; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
      awaddr = 32'h8000_0020; awid = 4'd7; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
      wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      r_cyc = -1; aw_cyc = -1;
      for (int c = 0; c < 40 && (arvalid || awvalid || wvalid); c++) begin
         @(negedge clock);
         if (c == 0) begin
            chk("arb_arready", 32'(arready), 32'd1);
            chk("arb_awready", 32'(awready), 32'd0);
            chk("arb_wready",  32'(wready),  32'd0);
         end
         ar_done = arvalid && arready;
         aw_done = awvalid && awready;
         w_done  = wvalid && wready;
         if (rvalid && rready && r_cyc < 0) r_cyc = c;
         if (aw_done && aw_cyc < 0) aw_cyc = c;
         @(posedge clock); #1;
         if (ar_done) arvalid = 1'b0;
         if (aw_done) awvalid = 1'b0;
         if (w_done)  wvalid  = 1'b0;
      end
      chk("arb_write_after_read", 32'(aw_cyc), 32'(r_cyc + 1));
      wait_drain();

      // Read backpressure: response held stable while rready is low
      rready = 1'b0;
      issue_read(32'h8000_0020, 4'd9, 8'd0, 2'b00, 32'hCAFE_F00D, waited);
      for (int c = 0; c < 20 && !rvalid; c++) @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("stall_rvalid", 32'(rvalid), 32'd1);
         chk("stall_rdata",  rdata,       32'hCAFE_F00D);
         chk("stall_rid",    32'(rid),    32'd9);
      end
      @(posedge clock); #1;
      rready = 1'b1;
      @(negedge clock);
      @(posedge clock); #1;
      chk("stall_done_rvalid", 32'(rvalid), 32'd0);
      wait_drain();

      // Error responses and boundaries
      issue_write(32'h8000_0000, 4'd1, 32'h0BAD_F00D, 4'hF, 1'b1, 2'b00, 1'b1);
      wait_drain();
      issue_write(32'h8000_1000, 4'd2, 32'h1234_5678, 4'hF, 1'b1, 2'b11, 1'b1);
      wait_drain();
      issue_read(32'h8000_0000, 4'd3, 8'd0, 2'b00, 32'h0BAD_F00D, waited);
      wait_drain();
      issue_read(32'h8000_0010, 4'd4, 8'd3, 2'b10, 32'h0, waited);
      wait_drain();
      issue_write(32'h8000_0020, 4'd5, 32'h5555_5555, 4'hF, 1'b0, 2'b10, 1'b1);
      wait_drain();
      issue_read(32'h8000_0020, 4'd6, 8'd0, 2'b00, 32'hCAFE_F00D, waited);
      wait_drain();
      issue_write(32'h8000_0FFC, 4'd7, 32'hA5A5_5A5A, 4'hF, 1'b1, 2'b00, 1'b1);
      wait_drain();
      issue_read(32'h8000_0FFC, 4'd8, 8'd0, 2'b00, 32'hA5A5_5A5A, waited);
      wait_drain();
      issue_read(32'h7FFF_FFFC, 4'd9, 8'd0, 2'b11, 32'h0, waited);
      wait_drain();

      // Reset while waiting: no response, no write, read accepted right away afterwards
      issue_write(32'h8000_0010, 4'd4, 32'hFFFF_FFFF, 4'hF, 1'b1, 2'b00, 1'b0);
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      bcnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (bvalid) bcnt++;
      end
      chk("bvalid_after_reset", 32'(bcnt), 32'd0);
      issue_read(32'h8000_0010, 4'd8, 8'd0, 2'b00, 32'hDEAD_3344, waited);
      chk("arready_after_reset", 32'(waited), 32'd0);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
